// File: rtl/chan_merge_rx.sv
// chan_merge_rx: return-path collector for the four-way channel fan-out.
// Forwards the selected channel's p-lines, df pair and valid onto a single
// registered host-side bus. A channel change drains through an idle window
// of HOLD_CYC cycles so the host never sees partial or mixed-channel data.
module chan_merge_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYC    = 4,
   parameter int CW          = 3
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic [1:0]  sel_req,
   input  logic [11:0] ch_p,
   input  logic [7:0]  ch_df,
   input  logic [3:0]  ch_vld,
   input  logic        err_clr,
   output logic [2:0]  p_out,
   output logic [1:0]  df_out,
   output logic        vld_out,
   output logic [1:0]  sel_cur,
   output logic        switching,
   output logic        err_o
);

   typedef enum logic {RUN, DRAIN} state_t;

   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC - 1);
   localparam logic [2:0]    P_IDLE    = 3'b111;
   localparam logic [1:0]    DF_IDLE   = 2'b00;

   state_t        state;
   logic [1:0]    target;
   logic [CW-1:0] cnt;
   logic [1:0]    sel_sync_pipe [SYNC_STAGES];
   logic [1:0]    sel_sync;
   logic [3:0]    sel_mask;
   logic          stray_vld;

   function automatic logic [2:0] pick_p(input logic [11:0] p, input logic [1:0] s);
      return p[3*s +: 3];
   endfunction

   function automatic logic [1:0] pick_df(input logic [7:0] d, input logic [1:0] s);
      return d[2*s +: 2];
   endfunction

   assign sel_sync  = sel_sync_pipe[SYNC_STAGES-1];
   assign sel_mask  = 4'b0001 << sel_cur;
   assign stray_vld = |(ch_vld & ~sel_mask);

   // Synchronise the asynchronous channel request into clk_in
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sel_sync_pipe[i] <= '0;
      end else begin
         sel_sync_pipe[0] <= sel_req;
         for (int i = 1; i < SYNC_STAGES; i++) sel_sync_pipe[i] <= sel_sync_pipe[i-1];
      end
   end

   // RUN/DRAIN control with registered host-side outputs
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         target    <= '0;
         cnt       <= '0;
         sel_cur   <= '0;
         switching <= 1'b0;
         p_out     <= P_IDLE;
         df_out    <= DF_IDLE;
         vld_out   <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (sel_sync != sel_cur) begin
                  // Go idle on the very edge the change is seen
                  state     <= DRAIN;
                  target    <= sel_sync;
                  cnt       <= HOLD_LOAD;
                  switching <= 1'b1;
                  p_out     <= P_IDLE;
                  df_out    <= DF_IDLE;
                  vld_out   <= 1'b0;
               end else begin
                  p_out   <= pick_p(ch_p, sel_cur);
                  df_out  <= pick_df(ch_df, sel_cur);
                  vld_out <= ch_vld[sel_cur];
               end
            end
            DRAIN: begin
               if (sel_sync != target) begin
                  // Request moved again: restart the whole window
                  target  <= sel_sync;
                  cnt     <= HOLD_LOAD;
                  p_out   <= P_IDLE;
                  df_out  <= DF_IDLE;
                  vld_out <= 1'b0;
               end else if (cnt == '0) begin
                  // Exit edge registers the new channel's first sample, so the
                  // idle window is exactly HOLD_CYC cycles long
                  state     <= RUN;
                  sel_cur   <= target;
                  switching <= 1'b0;
                  p_out     <= pick_p(ch_p, target);
                  df_out    <= pick_df(ch_df, target);
                  vld_out   <= ch_vld[target];
               end else begin
                  cnt     <= cnt - 1'b1;
                  p_out   <= P_IDLE;
                  df_out  <= DF_IDLE;
                  vld_out <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   // Sticky flag for valids on unselected channels while forwarding; set beats clear
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         err_o <= 1'b0;
      end else if (state == RUN && stray_vld) begin
         err_o <= 1'b1;
      end else if (err_clr) begin
         err_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_chan_merge_rx.sv
// Directed bench for chan_merge_rx with default parameters.
module tb_chan_merge_rx;

   logic        clk_in = 1'b0;
   logic        rst;
   logic [1:0]  sel_req;
   logic [11:0] ch_p;
   logic [7:0]  ch_df;
   logic [3:0]  ch_vld;
   logic        err_clr;
   logic [2:0]  p_out;
   logic [1:0]  df_out;
   logic        vld_out;
   logic [1:0]  sel_cur;
   logic        switching;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   chan_merge_rx #(.SYNC_STAGES(2), .HOLD_CYC(4), .CW(3)) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .sel_req   (sel_req),
      .ch_p      (ch_p),
      .ch_df     (ch_df),
      .ch_vld    (ch_vld),
      .err_clr   (err_clr),
      .p_out     (p_out),
      .df_out    (df_out),
      .vld_out   (vld_out),
      .sel_cur   (sel_cur),
      .switching (switching),
      .err_o     (err_o)
   );

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst     = 1'b0;
      sel_req = 2'd0;
      ch_p    = 12'hFFF;
      ch_df   = 8'h00;
      ch_vld  = 4'b0000;
      err_clr = 1'b0;
      tick();
      tick();
      chk("rst_p",   p_out,     3'b111);
      chk("rst_df",  df_out,    2'b00);
      chk("rst_vld", vld_out,   1'b0);
      chk("rst_sel", sel_cur,   2'd0);
      chk("rst_sw",  switching, 1'b0);
      chk("rst_err", err_o,     1'b0);

      // Forward channel 0 one edge after release
      ch_p   = {3'b110, 3'b101, 3'b011, 3'b010};
      ch_df  = {2'b11, 2'b01, 2'b11, 2'b10};
      ch_vld = 4'b0001;
      rst    = 1'b1;
      tick();
      chk("fwd0_p",   p_out,     3'b010);
      chk("fwd0_df",  df_out,    2'b10);
      chk("fwd0_vld", vld_out,   1'b1);
      chk("fwd0_sel", sel_cur,   2'd0);
      chk("fwd0_sw",  switching, 1'b0);

      // One-cycle bounce 0->2->0: drain entered, window restarts to 0
      sel_req = 2'd2;
      tick();
      sel_req = 2'd0;
      tick();
      chk("bnc_e2_sw", switching, 1'b0);
      tick();
      chk("bnc_e3_sw", switching, 1'b1);
      chk("bnc_e3_p",  p_out,     3'b111);
      chk("bnc_e3_vld", vld_out,  1'b0);
      for (int i = 0; i < 4; i++) tick();
      chk("bnc_e7_sw",  switching, 1'b1);
      chk("bnc_e7_sel", sel_cur,   2'd0);
      tick();
      chk("bnc_e8_sw",  switching, 1'b0);
      chk("bnc_e8_sel", sel_cur,   2'd0);
      chk("bnc_e8_p",   p_out,     3'b010);
      chk("bnc_e8_vld", vld_out,   1'b1);

      // Clean switch 0->2
      sel_req = 2'd2;
      tick();
      tick();
      chk("sw2_e2_sw", switching, 1'b0);
      chk("sw2_e2_p",  p_out,     3'b010);
      tick();
      chk("sw2_e3_sw",  switching, 1'b1);
      chk("sw2_e3_p",   p_out,     3'b111);
      chk("sw2_e3_df",  df_out,    2'b00);
      chk("sw2_e3_vld", vld_out,   1'b0);
      ch_vld = 4'b0100;
      for (int i = 4; i <= 6; i++) begin
         tick();
         chk("sw2_idle_p",  p_out,     3'b111);
         chk("sw2_idle_sw", switching, 1'b1);
      end
      tick();
      chk("sw2_e7_sw",  switching, 1'b0);
      chk("sw2_e7_sel", sel_cur,   2'd2);
      chk("sw2_e7_p",   p_out,     3'b101);
      chk("sw2_e7_df",  df_out,    2'b01);
      chk("sw2_e7_vld", vld_out,   1'b1);
      chk("sw2_e7_err", err_o,     1'b0);
      ch_p[2:0] = 3'b000;
      tick();
      chk("sw2_unsel_p", p_out, 3'b101);

      // Switch 2->1, redirected to 3 while draining
      sel_req = 2'd1;
      tick();
      tick();
      tick();
      chk("rs_e3_sw", switching, 1'b1);
      ch_vld  = 4'b1000;
      sel_req = 2'd3;
      tick();
      tick();
      tick();
      tick();
      chk("rs_e7_sel", sel_cur,   2'd2);
      chk("rs_e7_sw",  switching, 1'b1);
      tick();
      tick();
      chk("rs_e9_sw", switching, 1'b1);
      chk("rs_e9_p",  p_out,     3'b111);
      tick();
      chk("rs_e10_sw",  switching, 1'b0);
      chk("rs_e10_sel", sel_cur,   2'd3);
      chk("rs_e10_p",   p_out,     3'b110);
      chk("rs_e10_df",  df_out,    2'b11);
      chk("rs_e10_vld", vld_out,   1'b1);

      // Stray-valid flag with sel_cur=3
      chk("err_init", err_o, 1'b0);
      ch_vld = 4'b0101;
      tick();
      chk("err_set",     err_o,   1'b1);
      chk("err_set_vld", vld_out, 1'b0);
      ch_vld = 4'b1000;
      tick();
      tick();
      chk("err_sticky", err_o, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr", err_o, 1'b0);
      err_clr = 1'b1;
      ch_vld  = 4'b1001;
      tick();
      chk("err_set_wins", err_o, 1'b1);
      ch_vld = 4'b1000;
      tick();
      err_clr = 1'b0;
      chk("err_clr2", err_o, 1'b0);

      // Back to 0, then reset in the middle of a drain toward 3
      sel_req = 2'd0;
      tick();
      tick();
      tick();
      ch_vld = 4'b0001;
      for (int i = 0; i < 4; i++) tick();
      chk("back0_sel", sel_cur,   2'd0);
      chk("back0_sw",  switching, 1'b0);
      chk("back0_err", err_o,     1'b0);
      sel_req = 2'd3;
      tick();
      tick();
      tick();
      chk("rd_sw_pre", switching, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk("rd_p",   p_out,     3'b111);
      chk("rd_df",  df_out,    2'b00);
      chk("rd_vld", vld_out,   1'b0);
      chk("rd_sel", sel_cur,   2'd0);
      chk("rd_sw",  switching, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      chk("rr_e1_p",   p_out,     3'b000);
      chk("rr_e1_vld", vld_out,   1'b1);
      chk("rr_e1_sw",  switching, 1'b0);
      tick();
      tick();
      chk("rr_e3_sw", switching, 1'b1);
      tick();
      tick();
      tick();
      chk("rr_e6_sw",  switching, 1'b1);
      chk("rr_e6_sel", sel_cur,   2'd0);
      tick();
      chk("rr_e7_sw",  switching, 1'b0);
      chk("rr_e7_sel", sel_cur,   2'd3);
      chk("rr_e7_p",   p_out,     3'b110);
      chk("rr_e7_vld", vld_out,   1'b0);
      chk("rr_e7_err", err_o,     1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
